// File: rtl/cdr_lock_ctrl.sv
// -----------------------------------------------------------------------------
// cdr_lock_ctrl
//
// Lock-acquisition sequencer for the CDR loop. It integrates the phase
// detector's per-transition early/late decisions over windows of
// 2^WIN_LOG2 transitions. The magnitude of each window's imbalance moves the
// loop through ACQ (high gain), TRACK (low gain) and LOCKED. A long absence of
// transitions parks the loop in HOLD with the NCO frozen until data returns.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          controller enable; low forces IDLE on the next edge
//   pd_valid    one-cycle strobe per detected data transition
//   pd_early    sampling early, qualified by pd_valid
//   pd_late     sampling late, qualified by pd_valid
//   gain_sel    loop gain: 0 none/frozen, 1 low (track), 2 high (acquire)
//   nco_freeze  hold NCO phase/frequency
//   locked      lock indication
//   loss_pulse  one-cycle pulse when lock is lost
//   state       IDLE=0, ACQ=1, TRACK=2, LOCKED=3, HOLD=4
//   win_err     |imbalance| of the last completed window
// -----------------------------------------------------------------------------
module cdr_lock_ctrl #(
  parameter int WIN_LOG2     = 6,
  parameter int ACQ_THR      = 16,
  parameter int LOCK_THR     = 8,
  parameter int UNLOCK_THR   = 24,
  parameter int LOCK_WINDOWS = 4,
  parameter int TIMEOUT      = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                pd_valid,
  input  logic                pd_early,
  input  logic                pd_late,
  output logic [1:0]          gain_sel,
  output logic                nco_freeze,
  output logic                locked,
  output logic                loss_pulse,
  output logic [2:0]          state,
  output logic [WIN_LOG2:0]   win_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACQ    = 3'd1,
    ST_TRACK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  // The running accumulator never holds more than 2^WIN_LOG2-1 transitions,
  // so WIN_LOG2+1 bits suffice for storage. The window-closing sum can reach
  // +/-2^WIN_LOG2, so it is formed one bit wider.
  localparam int MAG_W  = WIN_LOG2 + 2;
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [MAG_W-1:0]    MAG_ONE    = MAG_W'(1);
  localparam logic [MAG_W-1:0]    MAG_M_ONE  = {MAG_W{1'b1}};
  localparam logic [MAG_W-1:0]    ACQ_LIM    = MAG_W'(ACQ_THR);
  localparam logic [MAG_W-1:0]    LOCK_LIM   = MAG_W'(LOCK_THR);
  localparam logic [MAG_W-1:0]    UNLOCK_LIM = MAG_W'(UNLOCK_THR);
  localparam logic [WIN_LOG2-1:0] TCNT_ONE   = WIN_LOG2'(1);
  localparam logic [GOOD_W-1:0]   GOOD_ONE   = GOOD_W'(1);
  localparam logic [GOOD_W-1:0]   LOCK_CNT   = GOOD_W'(LOCK_WINDOWS);
  localparam logic [15:0]         IDLE_ONE   = 16'd1;
  localparam logic [15:0]         TIMEOUT_CNT = 16'(TIMEOUT);

  localparam logic [1:0] GAIN_NONE = 2'd0;
  localparam logic [1:0] GAIN_LOW  = 2'd1;
  localparam logic [1:0] GAIN_HIGH = 2'd2;

  state_e                state_q, state_d;
  state_e                saved_q, saved_d;
  logic [WIN_LOG2-1:0]   tcnt_q, tcnt_d;
  logic [WIN_LOG2:0]     acc_q, acc_d;
  logic [GOOD_W-1:0]     good_q, good_d;
  logic [15:0]           idle_q, idle_d;
  logic [WIN_LOG2:0]     win_err_q, win_err_d;
  logic [1:0]            gain_sel_q, gain_sel_d;
  logic                  nco_freeze_q, nco_freeze_d;
  logic                  locked_q, locked_d;
  logic                  loss_pulse_q, loss_pulse_d;

  // Datapath helpers
  logic [MAG_W-1:0]      delta;
  logic [MAG_W-1:0]      acc_sum;
  logic [MAG_W-1:0]      abs_mag;
  logic                  win_last;
  logic [GOOD_W-1:0]     good_inc;
  logic [15:0]           idle_sat;
  logic                  timeout_hit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    delta = '0;
    if (pd_early && !pd_late) begin
      delta = MAG_ONE;
    end else if (pd_late && !pd_early) begin
      delta = MAG_M_ONE;
    end

    // Sign-extend the stored accumulator before adding this sample.
    acc_sum  = {acc_q[WIN_LOG2], acc_q} + delta;
    abs_mag  = acc_sum[MAG_W-1] ? (~acc_sum + MAG_ONE) : acc_sum;
    win_last = (tcnt_q == '1);
    good_inc = good_q + GOOD_ONE;
    idle_sat = (idle_q == 16'hFFFF) ? idle_q : (idle_q + IDLE_ONE);
    timeout_hit = (idle_sat >= TIMEOUT_CNT);
  end

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    tcnt_d       = tcnt_q;
    acc_d        = acc_q;
    good_d       = good_q;
    idle_d       = idle_q;
    win_err_d    = win_err_q;
    loss_pulse_d = 1'b0;

    if (!en) begin
      // Disable wins over everything, including a window closing this cycle.
      state_d = ST_IDLE;
      tcnt_d  = '0;
      acc_d   = '0;
      good_d  = '0;
      idle_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
          tcnt_d  = '0;
          acc_d   = '0;
          good_d  = '0;
          idle_d  = '0;
        end

        ST_HOLD: begin
          // The transition that ends HOLD is discarded; the loop restarts
          // with an empty window in the state it was parked from.
          if (pd_valid) begin
            state_d = saved_q;
            tcnt_d  = '0;
            acc_d   = '0;
            idle_d  = '0;
          end
        end

        ST_ACQ, ST_TRACK, ST_LOCKED: begin
          if (pd_valid) begin
            // A transition this cycle always beats the timeout.
            idle_d = '0;
            if (win_last) begin
              tcnt_d    = '0;
              acc_d     = '0;
              win_err_d = abs_mag[WIN_LOG2:0];
              unique case (state_q)
                ST_ACQ: begin
                  if (abs_mag <= ACQ_LIM) begin
                    state_d = ST_TRACK;
                    good_d  = '0;
                  end
                end
                ST_TRACK: begin
                  if (abs_mag <= LOCK_LIM) begin
                    good_d = good_inc;
                    if (good_inc >= LOCK_CNT) begin
                      state_d = ST_LOCKED;
                    end
                  end else if (abs_mag > ACQ_LIM) begin
                    state_d = ST_ACQ;
                  end else begin
                    // Moderate error: stay, but lock needs a fresh run.
                    good_d = '0;
                  end
                end
                default: begin
                  if (abs_mag > UNLOCK_LIM) begin
                    state_d      = ST_ACQ;
                    loss_pulse_d = 1'b1;
                  end
                end
              endcase
            end else begin
              tcnt_d = tcnt_q + TCNT_ONE;
              acc_d  = acc_sum[WIN_LOG2:0];
            end
          end else begin
            idle_d = idle_sat;
            if (timeout_hit) begin
              state_d = ST_HOLD;
              saved_d = state_q;
              idle_d  = '0;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    gain_sel_d   = GAIN_NONE;
    nco_freeze_d = 1'b1;
    locked_d     = 1'b0;
    unique case (state_d)
      ST_ACQ: begin
        gain_sel_d   = GAIN_HIGH;
        nco_freeze_d = 1'b0;
      end
      ST_TRACK: begin
        gain_sel_d   = GAIN_LOW;
        nco_freeze_d = 1'b0;
      end
      ST_LOCKED: begin
        gain_sel_d   = GAIN_LOW;
        nco_freeze_d = 1'b0;
        locked_d     = 1'b1;
      end
      ST_HOLD: begin
        // Lock status is retained through a data outage.
        locked_d = locked_q;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      saved_q      <= ST_IDLE;
      tcnt_q       <= '0;
      acc_q        <= '0;
      good_q       <= '0;
      idle_q       <= '0;
      win_err_q    <= '0;
      gain_sel_q   <= GAIN_NONE;
      nco_freeze_q <= 1'b1;
      locked_q     <= 1'b0;
      loss_pulse_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge
      // values; blocking ones here would make results depend on statement
      // order.
      state_q      <= state_d;
      saved_q      <= saved_d;
      tcnt_q       <= tcnt_d;
      acc_q        <= acc_d;
      good_q       <= good_d;
      idle_q       <= idle_d;
      win_err_q    <= win_err_d;
      gain_sel_q   <= gain_sel_d;
      nco_freeze_q <= nco_freeze_d;
      locked_q     <= locked_d;
      loss_pulse_q <= loss_pulse_d;
    end
  end

  assign state      = state_q;
  assign gain_sel   = gain_sel_q;
  assign nco_freeze = nco_freeze_q;
  assign locked     = locked_q;
  assign loss_pulse = loss_pulse_q;
  assign win_err    = win_err_q;

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cdr_lock_ctrl
//
// Directed scenarios plus a randomized run for cdr_lock_ctrl. A behavioural
// model tracks window sample counts, the running early-minus-late sum, the
// good-window count and the idle-cycle count as plain integers and is stepped
// on every clock edge alongside the DUT.
// -----------------------------------------------------------------------------
module tb_cdr_lock_ctrl;

  localparam int WIN_LOG2 = 6;
  localparam int WIN_LEN  = 1 << WIN_LOG2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                pd_valid = 1'b0;
  logic                pd_early = 1'b0;
  logic                pd_late = 1'b0;
  logic [1:0]          gain_sel;
  logic                nco_freeze;
  logic                locked;
  logic                loss_pulse;
  logic [2:0]          state;
  logic [WIN_LOG2:0]   win_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdr_lock_ctrl #(
    .WIN_LOG2     (WIN_LOG2),
    .ACQ_THR      (16),
    .LOCK_THR     (8),
    .UNLOCK_THR   (24),
    .LOCK_WINDOWS (4),
    .TIMEOUT      (256)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pd_valid   (pd_valid),
    .pd_early   (pd_early),
    .pd_late    (pd_late),
    .gain_sel   (gain_sel),
    .nco_freeze (nco_freeze),
    .locked     (locked),
    .loss_pulse (loss_pulse),
    .state      (state),
    .win_err    (win_err)
  );

  // ---------------------------------------------------------------------------
  // Reference model: mode numbers follow the published state codes.
  // ---------------------------------------------------------------------------
  int m_state, m_saved, m_cnt, m_sum, m_good, m_idle, m_err;
  bit m_locked, m_loss;

  function automatic void model_reset();
    m_state = 0; m_saved = 0; m_cnt = 0; m_sum = 0; m_good = 0;
    m_idle = 0; m_err = 0; m_locked = 0; m_loss = 0;
  endfunction

  function automatic void model_close_window();
    int err;
    err = (m_sum < 0) ? -m_sum : m_sum;
    m_err = err;
    m_cnt = 0;
    m_sum = 0;
    if (m_state == 1) begin
      if (err <= 16) begin m_state = 2; m_good = 0; end
    end else if (m_state == 2) begin
      if (err <= 8) begin
        m_good++;
        if (m_good >= 4) begin m_state = 3; m_locked = 1; end
      end else if (err > 16) begin
        m_state = 1;
      end else begin
        m_good = 0;
      end
    end else begin
      if (err > 24) begin m_state = 1; m_locked = 0; m_loss = 1; end
    end
  endfunction

  function automatic void model_step(input bit en_i, input bit v, input bit e, input bit l);
    m_loss = 0;
    if (!en_i) begin
      m_state = 0; m_cnt = 0; m_sum = 0; m_good = 0; m_idle = 0; m_locked = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_cnt = 0; m_sum = 0; m_good = 0; m_idle = 0;
    end else if (m_state == 4) begin
      if (v) begin
        m_state = m_saved; m_cnt = 0; m_sum = 0; m_idle = 0;
        m_locked = (m_saved == 3);
      end
    end else if (v) begin
      m_idle = 0;
      m_cnt++;
      if (e && !l) m_sum++;
      else if (l && !e) m_sum--;
      if (m_cnt == WIN_LEN) model_close_window();
    end else begin
      m_idle++;
      if (m_idle >= 256) begin m_saved = m_state; m_state = 4; m_idle = 0; end
    end
  endfunction

  function automatic logic [1:0] exp_gain();
    case (m_state)
      1:       return 2'd2;
      2, 3:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic exp_freeze();
    return (m_state == 0) || (m_state == 4);
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change just after a falling edge, the DUT and the model
  // both advance on the rising edge, and tasks return at the next falling
  // edge where outputs are stable.
  // ---------------------------------------------------------------------------
  task automatic step(input bit en_i, input bit v, input bit e, input bit l);
    en = en_i; pd_valid = v; pd_early = e; pd_late = l;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(en_i, v, e, l);
    @(negedge clk);
  endtask

  // Interleaves early and late samples (early first), with short random gaps.
  task automatic send_mix(input int n_early, input int n_late);
    int e_left = n_early;
    int l_left = n_late;
    int k = 0;
    while (e_left + l_left > 0) begin
      repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 1'b0, 1'b0);
      if (e_left > 0 && ((k % 2 == 0) || l_left == 0)) begin
        step(1'b1, 1'b1, 1'b1, 1'b0); e_left--;
      end else begin
        step(1'b1, 1'b1, 1'b0, 1'b1); l_left--;
      end
      k++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (6) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state); end
    total++; if (gain_sel !== 2'd0) begin bad++; $display("FAIL rst_gain: got %0d want 0", gain_sel); end
    total++; if (nco_freeze !== 1'b1) begin bad++; $display("FAIL rst_freeze: got %b want 1", nco_freeze); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b want 0", locked); end
    total++; if (win_err !== 7'd0) begin bad++; $display("FAIL rst_win_err: got %0d want 0", win_err); end
    total++; if (loss_pulse !== 1'b0) begin bad++; $display("FAIL rst_loss: got %b want 0", loss_pulse); end
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL rst_release_state: got %0d want 1", state); end
    total++; if (gain_sel !== 2'd2) begin bad++; $display("FAIL rst_release_gain: got %0d want 2", gain_sel); end
  endtask

  task automatic test_acq_fail();
    send_mix(63, 0);
    total++; if (win_err !== 7'd0) begin bad++; $display("FAIL acqf_early_close: got win_err %0d want 0", win_err); end
    send_mix(1, 0);
    total++; if (win_err !== 7'd64) begin bad++; $display("FAIL acqf_win_err: got %0d want 64", win_err); end
    total++; if (state !== 3'd1) begin bad++; $display("FAIL acqf_state: got %0d want 1", state); end
    total++; if (gain_sel !== 2'd2) begin bad++; $display("FAIL acqf_gain: got %0d want 2", gain_sel); end
  endtask

  task automatic test_lock();
    send_mix(32, 31);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL lock_pre_track: got %0d want 1", state); end
    send_mix(0, 1);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL lock_track: got %0d want 2", state); end
    total++; if (win_err !== 7'd0) begin bad++; $display("FAIL lock_win_err0: got %0d want 0", win_err); end
    for (int w = 0; w < 3; w++) begin
      send_mix(32, 32);
      total++; if (state !== 3'd2) begin bad++; $display("FAIL lock_good%0d: got %0d want 2", w, state); end
    end
    send_mix(32, 31);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early: got %b want 0", locked); end
    send_mix(0, 1);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL lock_state: got %0d want 3", state); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_flag: got %b want 1", locked); end
    total++; if (gain_sel !== 2'd1) begin bad++; $display("FAIL lock_gain: got %0d want 1", gain_sel); end
  endtask

  task automatic test_loss();
    send_mix(40, 24);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL loss_keep_state: got %0d want 3", state); end
    total++; if (win_err !== 7'd16) begin bad++; $display("FAIL loss_keep_err: got %0d want 16", win_err); end
    total++; if (loss_pulse !== 1'b0) begin bad++; $display("FAIL loss_keep_pulse: got %b want 0", loss_pulse); end
    send_mix(48, 16);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL loss_state: got %0d want 1", state); end
    total++; if (loss_pulse !== 1'b1) begin bad++; $display("FAIL loss_pulse_hi: got %b want 1", loss_pulse); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_locked: got %b want 0", locked); end
    total++; if (win_err !== 7'd32) begin bad++; $display("FAIL loss_err: got %0d want 32", win_err); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (loss_pulse !== 1'b0) begin bad++; $display("FAIL loss_pulse_lo: got %b want 0", loss_pulse); end
  endtask

  task automatic test_hold();
    repeat (5) send_mix(32, 32);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL hold_relock: got %0d want 3", state); end
    repeat (255) step(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL hold_early: got %0d want 3", state); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (state !== 3'd4) begin bad++; $display("FAIL hold_state: got %0d want 4", state); end
    total++; if (nco_freeze !== 1'b1) begin bad++; $display("FAIL hold_freeze: got %b want 1", nco_freeze); end
    total++; if (gain_sel !== 2'd0) begin bad++; $display("FAIL hold_gain: got %0d want 0", gain_sel); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL hold_locked: got %b want 1", locked); end
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (state !== 3'd4) begin bad++; $display("FAIL hold_stay: got %0d want 4", state); end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL hold_return: got %0d want 3", state); end
    total++; if (nco_freeze !== 1'b0) begin bad++; $display("FAIL hold_return_freeze: got %b want 0", nco_freeze); end
    send_mix(63, 0);
    total++; if (state !== 3'd3) begin bad++; $display("FAIL hold_discard: got %0d want 3", state); end
    send_mix(1, 0);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL hold_full_window: got %0d want 1", state); end
    total++; if (win_err !== 7'd64) begin bad++; $display("FAIL hold_win_err: got %0d want 64", win_err); end
  endtask

  task automatic test_abort();
    send_mix(32, 32);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL abort_track: got %0d want 2", state); end
    send_mix(15, 15);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL abort_idle: got %0d want 0", state); end
    total++; if (nco_freeze !== 1'b1 || gain_sel !== 2'd0) begin
      bad++; $display("FAIL abort_outputs: got freeze %b gain %0d want 1 0", nco_freeze, gain_sel);
    end
    total++; if (win_err !== 7'd0) begin bad++; $display("FAIL abort_err_hold: got %0d want 0", win_err); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL abort_reacq: got %0d want 1", state); end
    send_mix(32, 31);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL abort_fresh: got %0d want 1", state); end
    send_mix(0, 1);
    total++; if (state !== 3'd2) begin bad++; $display("FAIL abort_track2: got %0d want 2", state); end
  endtask

  task automatic test_en_close();
    send_mix(63, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL enclose_state: got %0d want 0", state); end
    total++; if (win_err !== 7'd0) begin bad++; $display("FAIL enclose_err: got %0d want 0", win_err); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL enclose_reacq: got %0d want 1", state); end
  endtask

  task automatic test_reset_locked();
    repeat (5) send_mix(32, 32);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL rstl_locked: got %b want 1", locked); end
    send_mix(5, 5);
    rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL rstl_async_locked: got %b want 0", locked); end
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rstl_async_state: got %0d want 0", state); end
    total++; if (win_err !== 7'd0) begin bad++; $display("FAIL rstl_async_err: got %0d want 0", win_err); end
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0);
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rstl_held: got %0d want 0", state); end
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (state !== 3'd1) begin bad++; $display("FAIL rstl_release: got %0d want 1", state); end
  endtask

  task automatic test_random();
    int pe_tab[5] = '{50, 40, 90, 60, 30};
    int pl_tab[5] = '{50, 40, 10, 30, 30};
    int sel = 0;
    logic [14:0] act, exp;
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) sel = $urandom_range(0, 4);
      if (i % 1500 == 700) begin
        repeat (258) begin
          step(1'b1, 1'b0, 1'b0, 1'b0);
          act = {state, gain_sel, nco_freeze, locked, loss_pulse, win_err};
          exp = {3'(m_state), exp_gain(), exp_freeze(), m_locked, m_loss, 7'(m_err)};
          total++; if (act !== exp) begin bad++; $display("FAIL rand_gap %0d: got %h want %h", i, act, exp); end
        end
      end
      step(1'($urandom_range(0, 499) != 0), 1'($urandom_range(0, 99) < 70),
           1'($urandom_range(0, 99) < pe_tab[sel]), 1'($urandom_range(0, 99) < pl_tab[sel]));
      act = {state, gain_sel, nco_freeze, locked, loss_pulse, win_err};
      exp = {3'(m_state), exp_gain(), exp_freeze(), m_locked, m_loss, 7'(m_err)};
      total++; if (act !== exp) begin bad++; $display("FAIL rand_step %0d: got %h want %h", i, act, exp); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_acq_fail();
    test_lock();
    test_loss();
    test_hold();
    test_abort();
    test_en_close();
    test_reset_locked();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
